// File: rtl/jt51_sep32_pkg.sv
// Shared constants and slot-index type for the 32-slot time-multiplexed bus.
package jt51_sep32_pkg;
  localparam int unsigned SEP32_N  = 32;
  localparam int unsigned SEP32_AW = 5;
  typedef logic [SEP32_AW-1:0] slot_t;
  localparam slot_t SEP32_LAST = 5'd31;
endpackage

// File: rtl/sep32_slot_seq.sv
// Slot sequencer: slot counter, slot-0 strobe, frame counter and wrap pulse.
module sep32_slot_seq
  import jt51_sep32_pkg::*;
#(
  parameter int unsigned FRAMEW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  output slot_t             slot,
  output logic              zero,
  output logic [FRAMEW-1:0] frame_cnt,
  output slot_t             next_slot,
  output logic              wrap
);

  assign next_slot = slot + slot_t'(1);
  // Pulse on the cen edge that takes slot 31 -> 0 (frame start).
  assign wrap      = cen & (slot == SEP32_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot      <= SEP32_LAST;
      zero      <= 1'b0;
      frame_cnt <= '0;
    end else if (cen) begin
      slot <= next_slot;
      zero <= (slot == SEP32_LAST);
      if (slot == SEP32_LAST) frame_cnt <= frame_cnt + FRAMEW'(1);
    end
  end

endmodule

// File: rtl/sep32_tx.sv
// Transmit end of the 32-slot bus; define SEP32_SHADOW_EN for an atomic shadow table.
module sep32_tx
  import jt51_sep32_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned FRAMEW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DW-1:0]     wr_data,
  input  logic              commit_req,
  output logic              commit_pend,
  output logic [4:0]        slot,
  output logic              zero,
  output logic [DW-1:0]     dout,
  output logic [FRAMEW-1:0] frame_cnt
);

  slot_t         next_slot;
  logic          wrap;
  logic [DW-1:0] active [SEP32_N];

  sep32_slot_seq #(.FRAMEW(FRAMEW)) u_seq (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .slot      (slot),
    .zero      (zero),
    .frame_cnt (frame_cnt),
    .next_slot (next_slot),
    .wrap      (wrap)
  );

`ifdef SEP32_SHADOW_EN
  logic [DW-1:0] shadow [SEP32_N];
  logic          commit;

  assign commit = wrap & commit_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SEP32_N; i++) shadow[i] <= '0;
    end else if (wr_en) begin
      shadow[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SEP32_N; i++) active[i] <= '0;
    end else if (commit) begin
      for (int unsigned i = 0; i < SEP32_N; i++) active[i] <= shadow[i];
    end
  end

  // A request arriving on the commit edge survives into the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             commit_pend <= 1'b0;
    else if (commit_req) commit_pend <= 1'b1;
    else if (commit)     commit_pend <= 1'b0;
  end

  // On the commit edge slot 0 is forwarded straight from the shadow table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       dout <= '0;
    else if (cen)  dout <= commit ? shadow[0] : active[next_slot];
  end
`else
  logic unused_commit_req;

  assign unused_commit_req = commit_req;
  assign commit_pend       = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SEP32_N; i++) active[i] <= '0;
    end else if (wr_en) begin
      active[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       dout <= '0;
    else if (cen)  dout <= active[next_slot];
  end
`endif

endmodule

// File: tb/tb_sep32_tx.sv
// Randomized self-checking bench for sep32_tx against a frame-level reference model.
module tb_sep32_tx;

`ifdef SEP32_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       commit_req = 1'b0;
  logic       commit_pend;
  logic [4:0] slot;
  logic       zero;
  logic [7:0] dout;
  logic [7:0] frame_cnt;

  sep32_tx #(.DW(8), .FRAMEW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cen         (cen),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit_req  (commit_req),
    .commit_pend (commit_pend),
    .slot        (slot),
    .zero        (zero),
    .dout        (dout),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  // Loopback receiver: reloads 1 when it samples zero, else counts.
  logic [4:0] rx_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst)      rx_cnt <= 5'd0;
    else if (cen) rx_cnt <= zero ? 5'd1 : rx_cnt + 5'd1;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: cen edge count since reset plus the two tables.
  int         n_cen;
  logic [7:0] m_act [32];
  logic [7:0] m_sh  [32];
  logic [7:0] m_dout;
  logic       m_pend;

  function automatic logic [4:0] m_slot();
    return (n_cen == 0) ? 5'd31 : 5'((n_cen - 1) % 32);
  endfunction

  function automatic logic m_zero();
    return (n_cen > 0) && (((n_cen - 1) % 32) == 0);
  endfunction

  function automatic logic [7:0] m_frames();
    return 8'(((n_cen + 31) / 32) % 256);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("slot", 32'(slot), 32'(m_slot()));
    chk("zero", 32'(zero), 32'(m_zero()));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames()));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("commit_pend", 32'(commit_pend), 32'(m_pend));
    if (n_cen >= 33) chk("loopback", 32'(rx_cnt), 32'(m_slot()));
  endtask

  task automatic model_reset();
    n_cen  = 0;
    m_dout = 8'h00;
    m_pend = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_act[i] = 8'h00;
      m_sh[i]  = 8'h00;
    end
  endtask

  // One clock: drive at negedge, update model at posedge, check 1 time unit later.
  task automatic step(input logic c, input logic we, input logic [4:0] a,
                      input logic [7:0] d, input logic cr);
    logic commit;
    @(negedge clk);
    cen = c; wr_en = we; wr_addr = a; wr_data = d; commit_req = cr;
    @(posedge clk);
    commit = SH && c && (m_slot() == 5'd31) && m_pend;
    if (c) begin
      n_cen++;
      m_dout = commit ? m_sh[0] : m_act[m_slot()];
    end
    if (commit) m_act = m_sh;
    if (we) begin
      if (SH) m_sh[a] = d;
      else    m_act[a] = d;
    end
    if (SH) begin
      if (cr)          m_pend = 1'b1;
      else if (commit) m_pend = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic run_to(input logic [4:0] target);
    for (int i = 0; i < 40 && m_slot() != target; i++) step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    chk("reset_slot31", 32'(slot), 32'd31);
    @(negedge clk);
    rst = 1'b0;

    // Free-running frames.
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    chk("two_frames", 32'(frame_cnt), 32'd2);

    // cen every 3rd clock.
    for (int i = 0; i < 96; i++) step((i % 3) == 2, 1'b0, 5'd0, 8'd0, 1'b0);

    // Fill k+0x40, then two frames out.
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 5'(k), 8'(k + 8'h40), 1'b0);
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);

    // Random writes, cen and commit pulses, including same-slot collisions.
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 5'($urandom),
           8'($urandom), ($urandom_range(0, 60) == 0));

    // Fill 0xA5, commit at slot 10.
    for (int k = 0; k < 32; k++) step(1'b0, 1'b1, 5'(k), 8'hA5, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    run_to(5'd10);
    step(1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);

    // Write slot 0 on the commit edge, commit again afterwards.
    step(1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
    run_to(5'd31);
    step(1'b1, 1'b1, 5'd0, 8'h77, 1'b0);
    step(1'b1, 1'b0, 5'd0, 8'd0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);

    // Mid-frame reset with a commit pending.
    run_to(5'd16);
    step(1'b1, 1'b1, 5'd3, 8'h3C, 1'b1);
    @(negedge clk);
    cen = 1'b0; wr_en = 1'b0; commit_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
    chk("post_reset_zero", 32'(zero), 32'd1);

    // Frame counter wrap.
    for (int i = 0; i < 8200; i++) step(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
